// File: rtl/ctrl_pipe_regs_if.sv
// Control-pipeline bundle: decoded ID controls in, per-stage registered controls out.
// The slave modport is the pipeline register block; master is the driver/observer side.
interface ctrl_pipe_regs_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_branch;
  logic             id_memread;
  logic             id_memtoreg;
  logic             id_memwrite;
  logic             id_regwrite;
  logic             id_alusrc;
  logic [1:0]       id_aluop;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] id_rd;
  logic             ex_branch_taken;
  logic             stall_id;
  logic             ex_valid;
  logic             ex_branch;
  logic             ex_memread;
  logic             ex_memtoreg;
  logic             ex_memwrite;
  logic             ex_regwrite;
  logic             ex_alusrc;
  logic [1:0]       ex_aluop;
  logic [REG_W-1:0] ex_rd;
  logic             mem_valid;
  logic             mem_branch;
  logic             mem_memread;
  logic             mem_memtoreg;
  logic             mem_memwrite;
  logic             mem_regwrite;
  logic [REG_W-1:0] mem_rd;
  logic             wb_valid;
  logic             wb_memtoreg;
  logic             wb_regwrite;
  logic [REG_W-1:0] wb_rd;
  logic [CNT_W-1:0] bubble_cnt;

  modport slave (
    input  id_valid, id_branch, id_memread, id_memtoreg, id_memwrite, id_regwrite,
           id_alusrc, id_aluop, id_rs1, id_rs2, id_rd, ex_branch_taken,
    output stall_id,
           ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_regwrite,
           ex_alusrc, ex_aluop, ex_rd,
           mem_valid, mem_branch, mem_memread, mem_memtoreg, mem_memwrite, mem_regwrite, mem_rd,
           wb_valid, wb_memtoreg, wb_regwrite, wb_rd, bubble_cnt
  );

  modport master (
    output id_valid, id_branch, id_memread, id_memtoreg, id_memwrite, id_regwrite,
           id_alusrc, id_aluop, id_rs1, id_rs2, id_rd, ex_branch_taken,
    input  stall_id,
           ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_regwrite,
           ex_alusrc, ex_aluop, ex_rd,
           mem_valid, mem_branch, mem_memread, mem_memtoreg, mem_memwrite, mem_regwrite, mem_rd,
           wb_valid, wb_memtoreg, wb_regwrite, wb_rd, bubble_cnt
  );
endinterface

// File: rtl/ctrl_pipe_regs.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use stall detection,
// taken-branch squash of the ID instruction and a saturating bubble counter.
module ctrl_pipe_regs #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  ctrl_pipe_regs_if.slave bus
);

  logic stall_s;
  logic bubble_s;
  logic count_s;
  logic rs_match_s;

  // Load-use hazard detection; a taken branch discards IF/ID so it masks the stall.
  always_comb begin
    rs_match_s = 1'b0;
    stall_s    = 1'b0;
    bubble_s   = 1'b0;
    count_s    = 1'b0;
    if ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2)) begin
      rs_match_s = 1'b1;
    end else begin
      rs_match_s = 1'b0;
    end
    if (bus.id_valid && bus.ex_valid && bus.ex_memread && (bus.ex_rd != {REG_W{1'b0}})
        && rs_match_s && !bus.ex_branch_taken) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
    bubble_s = bus.ex_branch_taken | stall_s | ~bus.id_valid;
    // Only bubbles that displace a real instruction are counted, once per cycle.
    count_s  = bus.id_valid & (bus.ex_branch_taken | stall_s);
  end

  assign bus.stall_id = stall_s;

  // Pipeline control registers and bubble counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_branch    <= 1'b0;
      bus.ex_memread   <= 1'b0;
      bus.ex_memtoreg  <= 1'b0;
      bus.ex_memwrite  <= 1'b0;
      bus.ex_regwrite  <= 1'b0;
      bus.ex_alusrc    <= 1'b0;
      bus.ex_aluop     <= 2'b00;
      bus.ex_rd        <= {REG_W{1'b0}};
      bus.mem_valid    <= 1'b0;
      bus.mem_branch   <= 1'b0;
      bus.mem_memread  <= 1'b0;
      bus.mem_memtoreg <= 1'b0;
      bus.mem_memwrite <= 1'b0;
      bus.mem_regwrite <= 1'b0;
      bus.mem_rd       <= {REG_W{1'b0}};
      bus.wb_valid     <= 1'b0;
      bus.wb_memtoreg  <= 1'b0;
      bus.wb_regwrite  <= 1'b0;
      bus.wb_rd        <= {REG_W{1'b0}};
      bus.bubble_cnt   <= {CNT_W{1'b0}};
    end else begin
      if (bubble_s) begin
        bus.ex_valid    <= 1'b0;
        bus.ex_branch   <= 1'b0;
        bus.ex_memread  <= 1'b0;
        bus.ex_memtoreg <= 1'b0;
        bus.ex_memwrite <= 1'b0;
        bus.ex_regwrite <= 1'b0;
        bus.ex_alusrc   <= 1'b0;
        bus.ex_aluop    <= 2'b00;
        bus.ex_rd       <= {REG_W{1'b0}};
      end else begin
        bus.ex_valid    <= 1'b1;
        bus.ex_branch   <= bus.id_branch;
        bus.ex_memread  <= bus.id_memread;
        bus.ex_memtoreg <= bus.id_memtoreg;
        bus.ex_memwrite <= bus.id_memwrite;
        bus.ex_regwrite <= bus.id_regwrite;
        bus.ex_alusrc   <= bus.id_alusrc;
        bus.ex_aluop    <= bus.id_aluop;
        bus.ex_rd       <= bus.id_rd;
      end
      bus.mem_valid    <= bus.ex_valid;
      bus.mem_branch   <= bus.ex_branch;
      bus.mem_memread  <= bus.ex_memread;
      bus.mem_memtoreg <= bus.ex_memtoreg;
      bus.mem_memwrite <= bus.ex_memwrite;
      bus.mem_regwrite <= bus.ex_regwrite;
      bus.mem_rd       <= bus.ex_rd;
      bus.wb_valid     <= bus.mem_valid;
      bus.wb_memtoreg  <= bus.mem_memtoreg;
      bus.wb_regwrite  <= bus.mem_regwrite;
      bus.wb_rd        <= bus.mem_rd;
      if (count_s && (bus.bubble_cnt != {CNT_W{1'b1}})) begin
        bus.bubble_cnt <= bus.bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        bus.bubble_cnt <= bus.bubble_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed bench for ctrl_pipe_regs: reset, latency, load-use, x0, flush,
// flush/stall priority, reset mid-stall and counter saturation (CNT_W=2 instance).
module tb_ctrl_pipe_regs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ctrl_pipe_regs_if #(.REG_W(5), .CNT_W(16)) bus ();
  ctrl_pipe_regs_if #(.REG_W(5), .CNT_W(2))  sif ();

  ctrl_pipe_regs #(.REG_W(5), .CNT_W(16)) dut     (.clk(clk), .rst_n(rst_n), .bus(bus));
  ctrl_pipe_regs #(.REG_W(5), .CNT_W(2))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(sif));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Generic driver for the main instance: {branch,memread,memtoreg,memwrite,regwrite,alusrc}
  task automatic drive(input logic v, input logic [5:0] c, input logic [1:0] op,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    bus.id_valid = v;
    {bus.id_branch, bus.id_memread, bus.id_memtoreg, bus.id_memwrite,
     bus.id_regwrite, bus.id_alusrc} = c;
    bus.id_aluop = op; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    #1;
  endtask

  task automatic drive_sat(input logic v, input logic [5:0] c, input logic [1:0] op,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    sif.id_valid = v;
    {sif.id_branch, sif.id_memread, sif.id_memtoreg, sif.id_memwrite,
     sif.id_regwrite, sif.id_alusrc} = c;
    sif.id_aluop = op; sif.id_rs1 = rs1; sif.id_rs2 = rs2; sif.id_rd = rd;
    #1;
  endtask

  localparam logic [5:0] C_RTYPE = 6'b000010;
  localparam logic [5:0] C_LW    = 6'b011011;
  localparam logic [5:0] C_SW    = 6'b000101;
  localparam logic [5:0] C_BEQ   = 6'b100000;
  localparam logic [5:0] C_NONE  = 6'b000000;

  task automatic test_reset();
    logic [40:0] all_s;
    rst_n = 1'b0;
    drive(1'b1, C_RTYPE, 2'b10, 5'd1, 5'd2, 5'd5);
    step(); step();
    all_s = {bus.ex_valid, bus.ex_branch, bus.ex_memread, bus.ex_memtoreg, bus.ex_memwrite,
             bus.ex_regwrite, bus.ex_alusrc, bus.ex_aluop, bus.ex_rd, bus.mem_valid,
             bus.mem_branch, bus.mem_memread, bus.mem_memtoreg, bus.mem_memwrite,
             bus.mem_regwrite, bus.mem_rd, bus.wb_valid, bus.wb_memtoreg, bus.wb_regwrite,
             bus.wb_rd};
    checks++; if (all_s !== 41'd0) begin errors++; $display("FAIL reset_regs got=%h exp=0", all_s); end
    checks++; if (bus.bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.bubble_cnt); end
    rst_n = 1'b1;
    step();
    drive(1'b0, C_NONE, 2'b00, 5'd0, 5'd0, 5'd0);
    checks++; if ({bus.ex_valid, bus.ex_regwrite, bus.ex_aluop, bus.ex_rd} !== {1'b1, 1'b1, 2'b10, 5'd5})
      begin errors++; $display("FAIL lat_ex got=%b exp=%b", {bus.ex_valid, bus.ex_regwrite, bus.ex_aluop, bus.ex_rd}, {1'b1, 1'b1, 2'b10, 5'd5}); end
    step();
    checks++; if ({bus.mem_valid, bus.mem_regwrite, bus.mem_rd, bus.ex_valid} !== {1'b1, 1'b1, 5'd5, 1'b0})
      begin errors++; $display("FAIL lat_mem got=%b exp=%b", {bus.mem_valid, bus.mem_regwrite, bus.mem_rd, bus.ex_valid}, {1'b1, 1'b1, 5'd5, 1'b0}); end
    step();
    checks++; if ({bus.wb_valid, bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd} !== {1'b1, 1'b1, 1'b0, 5'd5})
      begin errors++; $display("FAIL lat_wb got=%b exp=%b", {bus.wb_valid, bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd}, {1'b1, 1'b1, 1'b0, 5'd5}); end
    checks++; if (bus.bubble_cnt !== 16'd0) begin errors++; $display("FAIL idle_uncounted got=%0d exp=0", bus.bubble_cnt); end
  endtask

  task automatic test_load_use();
    drive(1'b1, C_LW, 2'b00, 5'd1, 5'd0, 5'd7);
    step();
    drive(1'b1, C_RTYPE, 2'b10, 5'd7, 5'd2, 5'd8);
    checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", bus.stall_id); end
    step();
    checks++; if ({bus.ex_valid, bus.mem_memread, bus.mem_rd} !== {1'b0, 1'b1, 5'd7})
      begin errors++; $display("FAIL lu_bubble got=%b exp=%b", {bus.ex_valid, bus.mem_memread, bus.mem_rd}, {1'b0, 1'b1, 5'd7}); end
    checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got=%b exp=0", bus.stall_id); end
    checks++; if (bus.bubble_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", bus.bubble_cnt); end
    step();
    drive(1'b0, C_NONE, 2'b00, 5'd0, 5'd0, 5'd0);
    checks++; if ({bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_rd} !== {1'b1, 1'b1, 1'b0, 5'd8})
      begin errors++; $display("FAIL lu_advance got=%b exp=%b", {bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_rd}, {1'b1, 1'b1, 1'b0, 5'd8}); end
    step();
  endtask

  task automatic test_no_hazard();
    drive(1'b1, C_LW, 2'b00, 5'd1, 5'd0, 5'd0);
    step();
    drive(1'b1, C_RTYPE, 2'b10, 5'd0, 5'd0, 5'd9);
    checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL x0_nostall got=%b exp=0", bus.stall_id); end
    step();
    drive(1'b1, C_LW, 2'b00, 5'd1, 5'd0, 5'd7);
    step();
    drive(1'b1, C_RTYPE, 2'b10, 5'd3, 5'd4, 5'd10);
    checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL nomatch_nostall got=%b exp=0", bus.stall_id); end
    step();
    drive(1'b0, C_NONE, 2'b00, 5'd0, 5'd0, 5'd0);
    checks++; if ({bus.ex_valid, bus.ex_rd} !== {1'b1, 5'd10}) begin errors++; $display("FAIL nomatch_adv got=%b exp=%b", {bus.ex_valid, bus.ex_rd}, {1'b1, 5'd10}); end
    checks++; if (bus.bubble_cnt !== 16'd1) begin errors++; $display("FAIL nohaz_cnt got=%0d exp=1", bus.bubble_cnt); end
    step();
  endtask

  task automatic test_flush();
    drive(1'b1, C_BEQ, 2'b01, 5'd1, 5'd2, 5'd0);
    step();
    bus.ex_branch_taken = 1'b1;
    drive(1'b1, C_SW, 2'b00, 5'd3, 5'd4, 5'd0);
    step();
    bus.ex_branch_taken = 1'b0;
    drive(1'b0, C_NONE, 2'b00, 5'd0, 5'd0, 5'd0);
    checks++; if ({bus.ex_valid, bus.ex_memwrite, bus.mem_branch, bus.mem_valid} !== 4'b0011)
      begin errors++; $display("FAIL flush got=%b exp=0011", {bus.ex_valid, bus.ex_memwrite, bus.mem_branch, bus.mem_valid}); end
    checks++; if (bus.bubble_cnt !== 16'd2) begin errors++; $display("FAIL flush_cnt got=%0d exp=2", bus.bubble_cnt); end
    step();
  endtask

  task automatic test_priority();
    drive(1'b1, C_LW, 2'b00, 5'd1, 5'd0, 5'd9);
    step();
    bus.ex_branch_taken = 1'b1;
    drive(1'b1, C_RTYPE, 2'b10, 5'd9, 5'd2, 5'd11);
    checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL prio_stall got=%b exp=0", bus.stall_id); end
    step();
    bus.ex_branch_taken = 1'b0;
    drive(1'b0, C_NONE, 2'b00, 5'd0, 5'd0, 5'd0);
    checks++; if ({bus.ex_valid, bus.bubble_cnt} !== {1'b0, 16'd3})
      begin errors++; $display("FAIL prio_bubble got=%h exp=%h", {bus.ex_valid, bus.bubble_cnt}, {1'b0, 16'd3}); end
    step();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, C_LW, 2'b00, 5'd1, 5'd0, 5'd7);
    step();
    drive(1'b1, C_RTYPE, 2'b10, 5'd7, 5'd2, 5'd8);
    rst_n = 1'b0;
    step();
    checks++; if ({bus.stall_id, bus.ex_valid, bus.mem_valid, bus.bubble_cnt} !== {1'b0, 1'b0, 1'b0, 16'd0})
      begin errors++; $display("FAIL rst_mid_stall got=%h exp=0", {bus.stall_id, bus.ex_valid, bus.mem_valid, bus.bubble_cnt}); end
    rst_n = 1'b1;
    drive(1'b0, C_NONE, 2'b00, 5'd0, 5'd0, 5'd0);
    step();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_s;
    for (int i = 0; i < 5; i++) begin
      drive_sat(1'b1, C_LW, 2'b00, 5'd1, 5'd0, 5'd7);
      step();
      drive_sat(1'b1, C_RTYPE, 2'b10, 5'd7, 5'd2, 5'd8);
      step();
      drive_sat(1'b0, C_NONE, 2'b00, 5'd0, 5'd0, 5'd0);
      step();
      exp_s = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++; if (sif.bubble_cnt !== exp_s) begin errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, sif.bubble_cnt, exp_s); end
    end
  endtask

  initial begin
    bus.ex_branch_taken = 1'b0;
    sif.ex_branch_taken = 1'b0;
    drive_sat(1'b0, C_NONE, 2'b00, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_priority();
    test_reset_mid_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
